// File: rtl/sram_bank_sequencer.sv
// Sequences one SRAM bank access (read or write) across a fixed frame of PHASES phases.
// Latency: a request accepted in the last phase occupies the next full frame. Read data
//          is returned in the phase 0 that follows, PHASES+1 cycles after acceptance.
// Backpressure: requests are only taken in the last phase. Responses cannot be stalled.
//
// Ports:
//   clk, reset                    - single rising-edge clock, synchronous active-high reset
//   req_valid/req_ready           - request handshake. The fields are latched on acceptance.
//   req_write, req_addr_a/b,      - request fields
//   req_wdata
//   phase                         - current phase index, 0..PHASES-1
//   addr_a/b, wdata, read_en,     - registered bank controls
//   write_en, reg_wrt_bar
//   rd_data_a/b                   - bank read outputs, sampled in the last phase of a read frame
//   rsp_valid, rsp_data_a/b       - read response pulse and held read data
//   wr_done                       - write completion pulse
//   busy                          - a frame is in flight
module sram_bank_sequencer #(
  parameter int PHASES = 10,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr_a,
  input  logic [ADDR_W-1:0]         req_addr_b,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic [$clog2(PHASES)-1:0] phase,
  output logic [ADDR_W-1:0]         addr_a,
  output logic [ADDR_W-1:0]         addr_b,
  output logic [DATA_W-1:0]         wdata,
  output logic                      read_en,
  output logic                      write_en,
  output logic                      reg_wrt_bar,
  input  logic [DATA_W-1:0]         rd_data_a,
  input  logic [DATA_W-1:0]         rd_data_b,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_data_a,
  output logic [DATA_W-1:0]         rsp_data_b,
  output logic                      wr_done,
  output logic                      busy
);

  localparam int PW = $clog2(PHASES);
  localparam logic [PW-1:0] LAST     = PW'(PHASES - 1);
  localparam logic [PW-1:0] PH_ADDR  = PW'(2);
  localparam logic [PW-1:0] PH_WDATA = PW'(4);
  localparam logic [PW-1:0] PH_RWB   = PW'(6);
  localparam logic [PW-1:0] PH_RE0   = PW'(6);
  localparam logic [PW-1:0] PH_RE1   = PW'(7);
  localparam logic [PW-1:0] PH_WE    = PW'(8);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       phase_d;
  logic                lat_write_q, lat_write_d;
  logic [ADDR_W-1:0]   lat_a_q, lat_a_d, lat_b_q, lat_b_d;
  logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;

  logic                last_phase, accept, frame_d, wr_frame_d, rd_frame_d;
  logic                rd_capture;
  logic [ADDR_W-1:0]   addr_a_d, addr_b_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                read_en_d, write_en_d, reg_wrt_bar_d, rsp_valid_d, wr_done_d;

  always_comb begin
    last_phase    = (phase == LAST);
    // Acceptance is possible in either state, so readiness reduces to
    // "last phase". It is held low while reset is asserted.
    req_ready     = last_phase && !reset;
    accept        = req_valid && req_ready;
    phase_d       = last_phase ? '0 : phase + PW'(1);

    state_d       = state_q;
    if (last_phase) begin
      state_d = accept ? ACTIVE : IDLE;
    end

    lat_write_d   = accept ? req_write  : lat_write_q;
    lat_a_d       = accept ? req_addr_a : lat_a_q;
    lat_b_d       = accept ? req_addr_b : lat_b_q;
    lat_wdata_d   = accept ? req_wdata  : lat_wdata_q;

    // Bank outputs are registered, so they are decoded from the state, phase
    // and latched request that will be current in the next cycle.
    frame_d       = (state_d == ACTIVE);
    wr_frame_d    = frame_d && lat_write_d;
    rd_frame_d    = frame_d && !lat_write_d;

    addr_a_d      = (frame_d && phase_d >= PH_ADDR) ? lat_a_d : '0;
    addr_b_d      = (frame_d && phase_d >= PH_ADDR) ? lat_b_d : '0;
    wdata_d       = (wr_frame_d && phase_d >= PH_WDATA) ? lat_wdata_d : '0;
    reg_wrt_bar_d = wr_frame_d && (phase_d >= PH_RWB);
    write_en_d    = wr_frame_d && (phase_d == PH_WE);
    read_en_d     = rd_frame_d && (phase_d == PH_RE0 || phase_d == PH_RE1);

    // Frame completion is decided from the frame that is ending now. It does
    // not depend on any request accepted in the same cycle.
    rd_capture    = (state_q == ACTIVE) && last_phase && !lat_write_q;
    rsp_valid_d   = rd_capture;
    wr_done_d     = (state_q == ACTIVE) && last_phase && lat_write_q;

    busy          = (state_q == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      phase       <= '0;
      lat_write_q <= 1'b0;
      lat_a_q     <= '0;
      lat_b_q     <= '0;
      lat_wdata_q <= '0;
      addr_a      <= '0;
      addr_b      <= '0;
      wdata       <= '0;
      read_en     <= 1'b0;
      write_en    <= 1'b0;
      reg_wrt_bar <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data_a  <= '0;
      rsp_data_b  <= '0;
      wr_done     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase       <= phase_d;
      lat_write_q <= lat_write_d;
      lat_a_q     <= lat_a_d;
      lat_b_q     <= lat_b_d;
      lat_wdata_q <= lat_wdata_d;
      addr_a      <= addr_a_d;
      addr_b      <= addr_b_d;
      wdata       <= wdata_d;
      read_en     <= read_en_d;
      write_en    <= write_en_d;
      reg_wrt_bar <= reg_wrt_bar_d;
      rsp_valid   <= rsp_valid_d;
      wr_done     <= wr_done_d;
      if (rd_capture) begin
        rsp_data_a <= rd_data_a;
        rsp_data_b <= rd_data_b;
      end
    end
  end

endmodule

// File: doc/sram_bank_sequencer.md
SRAM_BANK_SEQUENCER -- requirements
Module: sram_bank_sequencer

Interface
REQ-001 Parameter PHASES, default 10, number of Bennett phases per frame.
REQ-002 Parameter DATA_W, default 16, bank data width.
REQ-003 Parameter ADDR_W, default 5, bank address width (32 words).
REQ-004 clk  input  1  single clock; every register in the block is clocked on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  requester holds a pending access.
REQ-007 req_ready  output  1  sequencer accepts the request this cycle.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_addr_a  input  ADDR_W  port A address (write target / read port A).
REQ-010 req_addr_b  input  ADDR_W  port B read address.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 phase  output  $clog2(PHASES)  current phase index.
REQ-013 addr_a, addr_b  output  ADDR_W  bank addresses.
REQ-014 wdata  output  DATA_W  bank write data.
REQ-015 read_en, write_en, reg_wrt_bar  output  1  bank control strobes.
REQ-016 rd_data_a, rd_data_b  input  DATA_W  bank read outputs.
REQ-017 rsp_valid  output  1  read response pulse.
REQ-018 rsp_data_a, rsp_data_b  output  DATA_W  captured read data.
REQ-019 wr_done  output  1  write completion pulse.
REQ-020 busy  output  1  access in flight.

Function
REQ-021 phase SHALL count 0..PHASES-1, advance by one each cycle, and wrap from PHASES-1 to 0.
REQ-022 FSM states SHALL be IDLE and ACTIVE; one access occupies exactly one full frame (phases 0..PHASES-1).
REQ-023 req_ready SHALL equal (state==IDLE or (state==ACTIVE and phase==PHASES-1)) and phase==PHASES-1; requests are only accepted in the last phase.
REQ-024 On req_valid&&req_ready the request fields SHALL be latched and state SHALL be ACTIVE in the following phase 0.
REQ-025 ACTIVE at phase PHASES-1 with no new acceptance SHALL return to IDLE; with acceptance SHALL remain ACTIVE (back-to-back frames, no bubble).
REQ-026 All bank outputs SHALL be registered: the value listed for phase p is present on the cycle where phase==p.
REQ-027 addr_a/addr_b SHALL carry latched addresses during phases 2..PHASES-1 of an ACTIVE frame, else 0.
REQ-028 wdata SHALL carry latched data during phases 4..PHASES-1 of an ACTIVE write frame, else 0.
REQ-029 reg_wrt_bar SHALL be 1 during phases 6..PHASES-1 of an ACTIVE write frame, else 0.
REQ-030 write_en SHALL be 1 only in phase 8 of an ACTIVE write frame.
REQ-031 read_en SHALL be 1 only in phases 6..7 of an ACTIVE read frame.
REQ-032 In phase PHASES-1 of an ACTIVE read frame rd_data_a/b SHALL be sampled; rsp_data_a/b update and rsp_valid pulses for exactly the next cycle (phase 0).
REQ-033 rsp_data_a/b SHALL hold their value until the next read capture.
REQ-034 wr_done SHALL pulse one cycle in phase 0 after an ACTIVE write frame.
REQ-035 busy SHALL equal (state==ACTIVE).
REQ-036 No response backpressure; read latency from acceptance to rsp_valid is PHASES+1 cycles.
REQ-037 req_valid low or request fields changing outside acceptance SHALL not affect an in-flight frame.

Reset
REQ-038 While reset is high at a clock edge: phase=0, state=IDLE, all outputs 0 (including req_ready, rsp_data_a/b).
REQ-039 Reset mid-frame SHALL abort the access: no write_en, rsp_valid or wr_done for it.
REQ-040 After reset release, first acceptance SHALL occur at the first phase==PHASES-1 (cycle 9).

Verification
REQ-041 Write addr_a=1, wdata=16'hAAAA accepted at phase 9 -> addr_a=1 from phase 2, wdata=AAAA from phase 4, reg_wrt_bar 6..9, write_en only phase 8, wr_done in next phase 0.
REQ-042 Read addr_a=1, addr_b=31, bank returns AAAA/0000 -> read_en phases 6..7, rsp_valid at phase 0 with rsp_data_a=AAAA, rsp_data_b=0000, write_en never 1.
REQ-043 req_valid held from phase 3 -> req_ready only at phase 9, acceptance there, no earlier strobes.
REQ-044 Write then read presented back-to-back -> two consecutive frames, busy continuously 1, wr_done and next frame addresses at same phase 0/2 as specified.
REQ-045 Reset at phase 7 of a write frame -> write_en never asserted, all outputs 0, phase restarts at 0.
REQ-046 Idle with req_valid=0 over 3 frames -> phase wraps 9->0 each frame, all strobes 0, busy 0.
